// File: rtl/mem_access_ctrl.sv
// Y86-64 memory-stage initiator: decodes icode into one read or write
// and runs it over a valid/ready request and valid-only response channel.
module mem_access_ctrl #(
  parameter int unsigned ADDR_LIMIT = 256,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [63:0] req_addr,
  output logic [63:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [63:0] rsp_rdata,
  output logic [63:0] valM,
  output logic        done,
  output logic        busy,
  output logic        mem_error
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_valid_q, req_valid_d;
  logic          req_we_q, req_we_d;
  logic [63:0]   req_addr_q, req_addr_d;
  logic [63:0]   req_wdata_q, req_wdata_d;
  logic [63:0]   valm_q, valm_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          dec_rd, dec_wr, dec_oob;
  logic [63:0]   dec_addr, dec_wdata;

  always_comb begin
    dec_rd    = 1'b0;
    dec_wr    = 1'b0;
    dec_addr  = valE;
    dec_wdata = valA;
    case (icode)
      4'h5: dec_rd = 1'b1;
      4'h9, 4'hB: begin
        dec_rd   = 1'b1;
        dec_addr = valA;
      end
      4'h4, 4'hA: dec_wr = 1'b1;
      4'h8: begin
        dec_wr    = 1'b1;
        dec_wdata = valP;
      end
      default: ;
    endcase
    dec_oob = dec_addr >= 64'(ADDR_LIMIT);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_valid_d = 1'b0;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    valm_d      = valm_q;
    done_d      = 1'b0;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (!(dec_rd || dec_wr)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (dec_oob) begin
            err_d   = 1'b1;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            req_we_d    = dec_wr;
            req_addr_d  = dec_addr;
            req_wdata_d = dec_wdata;
            req_valid_d = 1'b1;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        req_valid_d = 1'b1;
        // A response arriving alongside the handshake belongs to nobody yet.
        if (req_ready) begin
          req_valid_d = 1'b0;
          if (req_we_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RESP;
            cnt_d   = '0;
          end
        end
      end
      S_RESP: begin
        if (rsp_valid) begin
          valm_d  = rsp_rdata;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      valm_q      <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      valm_q      <= valm_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_we    = req_we_q;
  assign req_addr  = req_addr_q;
  assign req_wdata = req_wdata_q;
  assign valM      = valm_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign mem_error = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a latency/outcome model of each
// access is compared against the DUT on every cycle.
module tb_mem_access_ctrl;

  localparam int TO  = 15;
  localparam int LIM = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic [63:0] valA = '0, valE = '0, valP = '0;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [63:0] rsp_rdata = '0;
  logic        req_valid, req_we, done, busy, mem_error;
  logic [63:0] req_addr, req_wdata, valM;

  mem_access_ctrl #(.ADDR_LIMIT(LIM), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode),
    .valA(valA), .valE(valE), .valP(valP),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .valM(valM), .done(done), .busy(busy), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model of the current access: when it starts, how long it lasts and
  // what it leaves behind.
  bit          have = 0;
  int          s0, lat, rq_hi;
  bit          m_bus, m_we;
  logic [63:0] m_addr, m_wdata;
  bit          prev_err = 0, fin_err = 0;
  logic [63:0] prev_valm = '0, fin_valm = '0;

  task automatic plan(input logic [3:0] ic, input logic [63:0] a,
                      input logic [63:0] e, input logic [63:0] p,
                      input int rs, input int rsp, input logic [63:0] rd);
    bit r, w;
    logic [63:0] ad;
    if (have) begin
      prev_err  = fin_err;
      prev_valm = fin_valm;
    end
    r = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    w = (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
    ad = ((ic == 4'h9) || (ic == 4'hB)) ? a : e;
    m_bus   = (r || w) && (ad < LIM);
    m_we    = w;
    m_addr  = ad;
    m_wdata = (ic == 4'h8) ? p : a;
    rq_hi   = m_bus ? 1 + rs : 0;
    fin_err = ((r || w) && !m_bus) || (m_bus && r && rsp < 0);
    fin_valm = (m_bus && r && rsp >= 0) ? rd : prev_valm;
    if (!m_bus) lat = 1;
    else if (w) lat = 2 + rs;
    else if (rsp < 0) lat = 2 + rs + TO;
    else lat = 3 + rs + rsp;
    s0 = cyc;
    have = 1;
  endtask

  int          ck;
  logic        e_busy, e_done, e_rv, e_err;
  logic [63:0] e_valm;

  always @(negedge clk) begin
    if (!rst) begin
      e_busy = 1'b0;
      e_done = 1'b0;
      e_rv   = 1'b0;
      e_err  = prev_err;
      e_valm = prev_valm;
      if (have) begin
        ck     = cyc - s0;
        e_busy = (ck >= 1) && (ck <= lat);
        e_done = (ck == lat);
        e_rv   = m_bus && (ck >= 1) && (ck <= rq_hi);
        if (ck >= 1) e_err = (ck < lat) ? 1'b0 : fin_err;
        if (ck >= lat) e_valm = fin_valm;
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("req_valid", req_valid, e_rv);
      chk("mem_error", mem_error, e_err);
      chk("valM", valM, e_valm);
      if (e_rv) begin
        chk("req_we", req_we, m_we);
        chk("req_addr", req_addr, m_addr);
        chk("req_wdata", req_wdata, m_wdata);
      end
    end
  end

  int done_k, ndone, nrv, nhs;

  task automatic run(input logic [3:0] ic, input logic [63:0] a,
                     input logic [63:0] e, input logic [63:0] p,
                     input int rs, input int rsp, input logic [63:0] rd,
                     input bit spur, input bit spam);
    int n;
    @(negedge clk);
    icode = ic;
    valA  = a;
    valE  = e;
    valP  = p;
    start = 1'b1;
    plan(ic, a, e, p, rs, rsp, rd);
    n = lat + 2;
    done_k = 0;
    ndone  = 0;
    nrv    = 0;
    nhs    = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      start     = spam && (k < lat);
      req_ready = k >= 1 + rs;
      rsp_valid = (rsp >= 0 && k == 2 + rs + rsp) || (spur && k <= 1 + rs);
      rsp_rdata = (spur && k <= 1 + rs) ? 64'hBAD : rd;
      if (done) begin
        ndone++;
        done_k = k;
      end
      if (req_valid) nrv++;
      if (req_valid && req_ready) nhs++;
    end
    start     = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valM", valM, 0);
    chk("rst_addr", req_addr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(4'h8, 64'h77, 64'd16, 64'h40, 0, -1, '0, 0, 0);
    chk("call_done_cycle", done_k, 2);
    chk("call_handshakes", nhs, 1);
    chk("call_err", mem_error, 0);

    run(4'h5, '0, 64'd8, '0, 3, 0, 64'hDEAD, 1, 0);
    chk("mrmovq_done_cycle", done_k, 6);
    chk("mrmovq_pulses", ndone, 1);
    chk("mrmovq_valM", valM, 64'hDEAD);

    run(4'hB, 64'd300, '0, '0, 0, -1, '0, 0, 0);
    chk("popq_oob_done_cycle", done_k, 1);
    chk("popq_oob_req", nrv, 0);
    chk("popq_oob_err", mem_error, 1);

    run(4'h1, '0, '0, '0, 0, -1, '0, 0, 0);
    chk("opl_done_cycle", done_k, 1);
    chk("opl_err_clear", mem_error, 0);

    run(4'h9, 64'd4, '0, '0, 0, -1, '0, 0, 0);
    chk("ret_timeout_cycle", done_k, 17);
    chk("ret_timeout_err", mem_error, 1);
    chk("ret_valM_held", valM, 64'hDEAD);

    run(4'h4, 64'h1234, 64'd100, '0, 2, -1, '0, 0, 1);
    chk("rmmovq_spam_hs", nhs, 1);
    chk("rmmovq_spam_done", ndone, 1);
    chk("rmmovq_done_cycle", done_k, 4);

    run(4'h0, '0, '0, '0, 0, -1, '0, 0, 0);
    chk("halt_done_cycle", done_k, 1);
    chk("halt_no_req", nrv, 0);

    run(4'hA, 64'hCAFE, 64'd255, '0, 0, -1, '0, 0, 0);
    chk("pushq_edge_done", done_k, 2);
    chk("pushq_edge_err", mem_error, 0);

    run(4'h5, '0, 64'd256, '0, 0, 0, 64'h1, 0, 0);
    chk("mrmovq_oob_done", done_k, 1);
    chk("mrmovq_oob_err", mem_error, 1);
    chk("mrmovq_oob_valM", valM, 64'hDEAD);

    @(negedge clk);
    icode     = 4'hA;
    valE      = 64'd32;
    valA      = 64'd5;
    start     = 1'b1;
    req_ready = 1'b0;
    plan(4'hA, 64'd5, 64'd32, '0, 1000, -1, '0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_req_valid", req_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req_valid", req_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_valM", valM, 0);
    chk("async_rst_err", mem_error, 0);
    have      = 0;
    prev_err  = 0;
    prev_valm = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
